// File: rtl/exu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define EXU_MULDIV_FAST_MUL_EN to compute every multiply in a single cycle at accept.
module exu_muldiv #(
  parameter int ISA_WIDTH  = 32,
  parameter int FUNC_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FUNC_WIDTH-1:0] func,
  input  logic [ISA_WIDTH-1:0]  src_a,
  input  logic [ISA_WIDTH-1:0]  src_b,
  input  logic                  kill,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ISA_WIDTH-1:0]  result
);
  localparam int W     = ISA_WIDTH;
  localparam int CNT_W = $clog2(ISA_WIDTH);

  localparam logic [FUNC_WIDTH-1:0] F_MUL    = FUNC_WIDTH'(0);
  localparam logic [FUNC_WIDTH-1:0] F_MULH   = FUNC_WIDTH'(1);
  localparam logic [FUNC_WIDTH-1:0] F_MULHSU = FUNC_WIDTH'(2);
  localparam logic [FUNC_WIDTH-1:0] F_DIV    = FUNC_WIDTH'(4);
  localparam logic [FUNC_WIDTH-1:0] F_DIVU   = FUNC_WIDTH'(5);
  localparam logic [FUNC_WIDTH-1:0] F_REM    = FUNC_WIDTH'(6);
  localparam logic [FUNC_WIDTH-1:0] F_REMU   = FUNC_WIDTH'(7);
  localparam logic [W-1:0]          MIN_INT  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t                state;
  logic [CNT_W-1:0]      counter;
  logic [FUNC_WIDTH-1:0] func_q;
  logic [W-1:0]          op_a;
  logic [W-1:0]          op_b;
  logic [2*W-1:0]        acc;
  logic                  neg_res;

  logic         in_div, in_rem, in_signed_a, in_signed_b, in_neg_a, in_neg_b, in_neg;
  logic [W-1:0] in_mag_a, in_mag_b;
  logic         in_short;
  logic [W-1:0] in_short_result;

`ifdef EXU_MULDIV_FAST_MUL_EN
  logic signed [2*W-1:0] fast_a, fast_b;
  logic [2*W-1:0]        fast_prod;
  assign fast_a    = (2*W)'($signed({in_signed_a & src_a[W-1], src_a}));
  assign fast_b    = (2*W)'($signed({in_signed_b & src_b[W-1], src_b}));
  assign fast_prod = fast_a * fast_b;
`endif

  // Accept-time decode: magnitudes, result sign and the short (one-cycle) results.
  always_comb begin
    in_div          = (func == F_DIV) || (func == F_DIVU) || (func == F_REM) || (func == F_REMU);
    in_rem          = (func == F_REM) || (func == F_REMU);
    in_signed_a     = (func == F_MULH) || (func == F_MULHSU) || (func == F_DIV) || (func == F_REM);
    in_signed_b     = (func == F_MULH) || (func == F_DIV) || (func == F_REM);
    in_neg_a        = in_signed_a & src_a[W-1];
    in_neg_b        = in_signed_b & src_b[W-1];
    in_mag_a        = in_neg_a ? -src_a : src_a;
    in_mag_b        = in_neg_b ? -src_b : src_b;
    in_neg          = in_rem ? in_neg_a : (in_neg_a ^ in_neg_b);
    in_short        = 1'b0;
    in_short_result = '0;
    if (in_div && (src_b == '0)) begin
      in_short        = 1'b1;
      in_short_result = in_rem ? src_a : '1;
    end else if (((func == F_DIV) || (func == F_REM)) && (src_a == MIN_INT) && (src_b == '1)) begin
      in_short        = 1'b1;
      in_short_result = in_rem ? '0 : MIN_INT;
    end
`ifdef EXU_MULDIV_FAST_MUL_EN
    else if (!in_div) begin
      in_short        = 1'b1;
      in_short_result = (func == F_MUL) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
    end
`endif
  end

  logic           busy_div, busy_rem;
  logic [W:0]     mul_sum, div_trial;
  logic [2*W-1:0] step_acc, fin_prod;
  logic [W-1:0]   fin_quo, fin_rem, fin_result;

  // acc holds {high, low} of the product, or {remainder, quotient} while dividing.
  always_comb begin
    busy_div  = (func_q == F_DIV) || (func_q == F_DIVU) || (func_q == F_REM) || (func_q == F_REMU);
    busy_rem  = (func_q == F_REM) || (func_q == F_REMU);
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, op_a} : '0);
    div_trial = {acc[2*W-1:W], acc[W-1]} - {1'b0, op_b};
    if (busy_div) begin
      step_acc = div_trial[W] ? {acc[2*W-2:0], 1'b0} : {div_trial[W-1:0], acc[W-2:0], 1'b1};
    end else begin
      step_acc = {mul_sum, acc[W-1:1]};
    end
    fin_prod = neg_res ? -step_acc : step_acc;
    fin_quo  = neg_res ? -step_acc[W-1:0] : step_acc[W-1:0];
    fin_rem  = neg_res ? -step_acc[2*W-1:W] : step_acc[2*W-1:W];
    if (busy_div) begin
      fin_result = busy_rem ? fin_rem : fin_quo;
    end else if (func_q == F_MUL) begin
      fin_result = fin_prod[W-1:0];
    end else begin
      fin_result = fin_prod[2*W-1:W];
    end
  end

  // Short results enter DONE with out_valid low and raise it one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      counter   <= '0;
      func_q    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      neg_res   <= 1'b0;
    end else if (kill) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            func_q   <= func;
            op_a     <= in_mag_a;
            op_b     <= in_mag_b;
            neg_res  <= in_neg;
            counter  <= '0;
            acc      <= {{W{1'b0}}, (in_div ? in_mag_a : in_mag_b)};
            in_ready <= 1'b0;
            if (in_short) begin
              state  <= DONE;
              result <= in_short_result;
            end else begin
              state  <= BUSY;
            end
          end
        end
        BUSY: begin
          acc     <= step_acc;
          counter <= counter + 1'b1;
          if (counter == CNT_W'(W-1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= fin_result;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/exu_muldiv.md
Name: exu_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EXU, directly downstream of the ALU operand-select stage.
- Consumes the selected operand pair (`src_a`, `src_b`) plus an M-extension function code, and produces one 32-bit result per accepted request.
- Uses a valid/ready handshake on both input and output, so the control path stalls the pipeline while an operation is in flight.
- Shift-add multiplication and restoring division, one bit per cycle.

Parameters:
- `ISA_WIDTH`, 32, operand/result width; latency scales with it.
- `FUNC_WIDTH`, 3, width of `func`; encoding equals RV32M funct3.

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept a request.
- `func`  in  `FUNC_WIDTH`  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `src_a`  in  `ISA_WIDTH`  rs1 operand (multiplicand/dividend).
- `src_b`  in  `ISA_WIDTH`  rs2 operand (multiplier/divisor).
- `kill`  in  1  synchronous abort of the current operation.
- `out_valid`  out  1  `result` valid.
- `out_ready`  in  1  consumer takes result.
- `result`  out  `ISA_WIDTH`  operation result.

Behaviour:
- Reset (`rst`=0, asynchronous): state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, counter=0, all datapath registers=0. Reset mid-operation discards everything.
- States:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready` at edge T, latch func/operands:
    - special case → DONE;
    - otherwise → BUSY, counter=0.
  - BUSY: `in_ready`=0. One iteration per cycle. After `ISA_WIDTH` iterations (counter==`ISA_WIDTH`-1) → DONE.
    - Normal ops: `out_valid` first high in the cycle after edge T+32.
  - DONE: `out_valid`=1, `result` stable. On `out_ready` → IDLE.
    - Stall: `out_valid`/`result` are held indefinitely while `out_ready`=0.
- No input acceptance in DONE: `in_ready`=0 in BUSY and DONE (no overlap).
- Signedness:
  - MULH and DIV/REM: both operands signed.
  - MULHSU: `src_a` signed, `src_b` unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Magnitudes are taken at accept; the result is negated at DONE entry as required.
- Multiply:
  - 2×`ISA_WIDTH` product register, shift-add.
  - MUL returns low half (identical for all signedness); MULH* return high half of the sign-corrected product.
- Divide:
  - Restoring, quotient/remainder on magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Special cases (IDLE→DONE, `out_valid` after edge T+1):
  - divisor==0: DIV/DIVU → all ones; REM/REMU → `src_a`.
  - DIV with `src_a`=0x80000000, `src_b`=0xFFFFFFFF → 0x80000000; REM of same → 0.
- kill:
  - Sampled every edge; highest priority after reset.
  - In BUSY or DONE: next state IDLE, `out_valid`=0, `in_ready`=1.
  - kill together with `in_valid` in IDLE: request is NOT accepted.
- Simultaneous `out_ready` in DONE and `in_valid`: the new request is not accepted that cycle (`in_ready`=0); it is accepted on the following cycle.
- Operands, func, and `result` change only on handshake or state transitions; `src_a`/`src_b` may change freely after accept.

Optional Feature:
- Macro: `EXU_MULDIV_FAST_MUL_EN`.
- Defined: MUL/MULH/MULHSU/MULHU computed in one cycle with a combinational 33×33 signed multiply at accept; IDLE→DONE, `out_valid` after edge T+1. Division unchanged.
- Undefined: all multiplies take the iterative BUSY path (`ISA_WIDTH` cycles). Results are bit-identical in both builds.

Test Plan:
- MUL 7×6, `out_ready`=1 → `result`=42; `out_valid` after edge T+32 (T+1 with `EXU_MULDIV_FAST_MUL_EN`); `in_ready`=0 until DONE→IDLE.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0; MULHU same → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with `out_valid` one cycle after accept; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- Hold `out_ready`=0 for 10 cycles in DONE → `out_valid`/`result` stable, `in_valid` ignored; then `out_ready`=1 → IDLE, next request accepted following cycle.
- Assert `kill` at BUSY iteration 10, and separately deassert `rst` asynchronously mid-BUSY → `out_valid` never rises for that op, `in_ready`=1 next cycle; subsequent DIVU 9/3 → 3.
